// File: rtl/pwm_ramp_ctrl.sv
// Soft-start / slew-rate controller for the PWM duty-cycle input.
// Moves duty_out toward the effective target in bounded steps at a programmed
// rate, committing each new value only on a PWM period boundary.
module pwm_ramp_ctrl #(
  parameter int unsigned DUTY_W = 8,
  parameter int unsigned RATE_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DUTY_W-1:0] target_duty,
  input  logic [DUTY_W-1:0] step,
  input  logic [RATE_W-1:0] rate_div,
  input  logic              period_sync,
  output logic [DUTY_W-1:0] duty_out,
  output logic              busy,
  output logic              at_target,
  output logic              ramp_done
);

  typedef enum logic [1:0] {StIdle, StRamp, StCommit} state_e;

  state_e            state_q;
  logic [RATE_W-1:0] presc_q;
  logic [DUTY_W-1:0] pending_q;
  logic [DUTY_W-1:0] duty_q;
  logic              busy_q;
  logic              ramp_done_q;

  logic [DUTY_W-1:0] eff_target;
  logic [DUTY_W-1:0] step_eff;
  logic [DUTY_W-1:0] diff;
  logic [DUTY_W-1:0] delta;
  logic [DUTY_W-1:0] next_duty;
  logic              tick;

  // Effective target and clamped next step value
  always_comb begin
    eff_target = enable ? target_duty : '0;
    step_eff   = (step == '0) ? {{(DUTY_W-1){1'b0}}, 1'b1} : step;
    // The distance to the target always fits in DUTY_W bits, and the step is
    // clamped to it, so the add/subtract below can never wrap.
    if (eff_target >= duty_q) begin
      diff      = eff_target - duty_q;
      delta     = (step_eff < diff) ? step_eff : diff;
      next_duty = duty_q + delta;
    end else begin
      diff      = duty_q - eff_target;
      delta     = (step_eff < diff) ? step_eff : diff;
      next_duty = duty_q - delta;
    end
    tick = (presc_q == rate_div);
  end

  // Ramp sequencer with registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      presc_q     <= '0;
      pending_q   <= '0;
      duty_q      <= '0;
      busy_q      <= 1'b0;
      ramp_done_q <= 1'b0;
    end else begin
      ramp_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (eff_target != duty_q) begin
            state_q <= StRamp;
            presc_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        StRamp: begin
          if (tick) begin
            pending_q <= next_duty;
            state_q   <= StCommit;
          end else if (eff_target == duty_q) begin
            // Target moved back onto the applied duty while waiting
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            presc_q <= presc_q + {{(RATE_W-1){1'b0}}, 1'b1};
          end
        end
        StCommit: begin
          if (period_sync) begin
            duty_q  <= pending_q;
            presc_q <= '0;
            if (pending_q == eff_target) begin
              state_q     <= StIdle;
              busy_q      <= 1'b0;
              ramp_done_q <= 1'b1;
            end else begin
              state_q <= StRamp;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign duty_out  = duty_q;
  assign busy      = busy_q;
  assign ramp_done = ramp_done_q;
  assign at_target = !busy_q && (duty_q == eff_target);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed self-checking bench for pwm_ramp_ctrl.
module tb_pwm_ramp_ctrl;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [7:0]  target_duty;
  logic [7:0]  step;
  logic [15:0] rate_div;
  logic        period_sync;
  logic [7:0]  duty_out;
  logic        busy;
  logic        at_target;
  logic        ramp_done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int base;

  pwm_ramp_ctrl #(
    .DUTY_W(8),
    .RATE_W(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .target_duty(target_duty),
    .step       (step),
    .rate_div   (rate_div),
    .period_sync(period_sync),
    .duty_out   (duty_out),
    .busy       (busy),
    .at_target  (at_target),
    .ramp_done  (ramp_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count ramp_done pulses
  always @(posedge clk) if (ramp_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Idle a while so the ramp reaches COMMIT, then give one sync pulse
  task automatic pulse_after(input int gap);
    repeat (gap) tick();
    period_sync = 1'b1;
    tick();
    period_sync = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    target_duty = 8'h80;
    step        = 8'h10;
    rate_div    = 16'd3;
    period_sync = 1'b0;
    tick();
    check("rst_duty", {24'd0, duty_out}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    check("rst_done", {31'd0, ramp_done}, 32'h0);
    check("rst_at_target", {31'd0, at_target}, 32'h1);
    reset = 1'b0;
    tick();

    // Soft start 0x00 -> 0x80 in steps of 0x10
    base   = done_cnt;
    enable = 1'b1;
    #1;
    check("ss_at_target_low", {31'd0, at_target}, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      pulse_after(255);
      check("ss_duty", {24'd0, duty_out}, k * 16);
      if (k < 8) check("ss_busy", {31'd0, busy}, 32'h1);
    end
    check("ss_done", {31'd0, ramp_done}, 32'h1);
    check("ss_busy_end", {31'd0, busy}, 32'h0);
    check("ss_at_target", {31'd0, at_target}, 32'h1);
    tick();
    check("ss_done_clear", {31'd0, ramp_done}, 32'h0);
    check("ss_done_count", done_cnt - base, 32'h1);
    // Sync in IDLE is ignored
    pulse_after(0);
    check("idle_sync_duty", {24'd0, duty_out}, 32'h80);
    check("idle_sync_busy", {31'd0, busy}, 32'h0);

    // Clamped last step 0x80 -> 0x85
    target_duty = 8'h85;
    repeat (10) tick();
    check("clamp_wait_busy", {31'd0, busy}, 32'h1);
    check("clamp_wait_duty", {24'd0, duty_out}, 32'h80);
    pulse_after(0);
    check("clamp_duty", {24'd0, duty_out}, 32'h85);
    check("clamp_done", {31'd0, ramp_done}, 32'h1);
    check("clamp_at_target", {31'd0, at_target}, 32'h1);

    // Soft stop with saturating step
    enable = 1'b0;
    step   = 8'hFF;
    pulse_after(10);
    check("stop_duty", {24'd0, duty_out}, 32'h0);
    check("stop_done", {31'd0, ramp_done}, 32'h1);
    check("stop_busy", {31'd0, busy}, 32'h0);
    tick();
    check("stop_busy_after", {31'd0, busy}, 32'h0);
    check("stop_at_target", {31'd0, at_target}, 32'h1);

    // Step of zero, rate_div 0, sync held high
    step        = 8'h00;
    rate_div    = 16'd0;
    target_duty = 8'h03;
    enable      = 1'b1;
    period_sync = 1'b1;
    tick();
    check("z_e0_busy", {31'd0, busy}, 32'h1);
    check("z_e0_duty", {24'd0, duty_out}, 32'h0);
    tick();
    check("z_e1_duty", {24'd0, duty_out}, 32'h0);
    tick();
    check("z_e2_duty", {24'd0, duty_out}, 32'h1);
    tick();
    check("z_e3_duty", {24'd0, duty_out}, 32'h1);
    tick();
    check("z_e4_duty", {24'd0, duty_out}, 32'h2);
    check("z_e4_done", {31'd0, ramp_done}, 32'h0);
    tick();
    check("z_e5_duty", {24'd0, duty_out}, 32'h2);
    tick();
    check("z_e6_duty", {24'd0, duty_out}, 32'h3);
    check("z_e6_done", {31'd0, ramp_done}, 32'h1);
    check("z_e6_busy", {31'd0, busy}, 32'h0);
    period_sync = 1'b0;
    tick();
    check("z_done_clear", {31'd0, ramp_done}, 32'h0);

    // Reversal mid-ramp: 0x00 -> 0x40, retarget to 0x08 after 0x20
    reset       = 1'b1;
    enable      = 1'b0;
    step        = 8'h10;
    rate_div    = 16'd1;
    target_duty = 8'h40;
    tick();
    reset = 1'b0;
    tick();
    base   = done_cnt;
    enable = 1'b1;
    pulse_after(6);
    check("rev_duty1", {24'd0, duty_out}, 32'h10);
    pulse_after(6);
    check("rev_duty2", {24'd0, duty_out}, 32'h20);
    target_duty = 8'h08;
    pulse_after(6);
    check("rev_duty3", {24'd0, duty_out}, 32'h10);
    check("rev_busy3", {31'd0, busy}, 32'h1);
    pulse_after(6);
    check("rev_duty4", {24'd0, duty_out}, 32'h08);
    check("rev_done", {31'd0, ramp_done}, 32'h1);
    tick();
    check("rev_done_count", done_cnt - base, 32'h1);

    // Async reset while COMMIT holds pending = 0x30
    step        = 8'h28;
    target_duty = 8'h40;
    repeat (6) tick();
    check("ar_busy_pre", {31'd0, busy}, 32'h1);
    check("ar_duty_pre", {24'd0, duty_out}, 32'h08);
    base = done_cnt;
    #2;
    reset = 1'b1;
    #1;
    check("ar_duty", {24'd0, duty_out}, 32'h0);
    check("ar_busy", {31'd0, busy}, 32'h0);
    check("ar_done", {31'd0, ramp_done}, 32'h0);
    enable      = 1'b0;
    period_sync = 1'b1;
    tick();
    tick();
    check("ar_duty_held", {24'd0, duty_out}, 32'h0);
    reset       = 1'b0;
    period_sync = 1'b0;
    tick();
    check("ar_duty_post", {24'd0, duty_out}, 32'h0);
    check("ar_busy_post", {31'd0, busy}, 32'h0);
    check("ar_at_target", {31'd0, at_target}, 32'h1);
    check("ar_done_count", done_cnt - base, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Soft-start and slew-rate controller that sequences the duty-cycle input of the PWM block. It sits between the register-bank configuration fields (target duty, step, rate, enable) and the PWM `duty_cycle` input. It moves the applied duty toward the target in bounded steps at a programmed rate, and it commits each new value only at a PWM period boundary so the PWM output never glitches.

## Interface
Parameters:
- `DUTY_W`, default 8: width of all duty and step values.
- `RATE_W`, default 16: width of the rate prescaler.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `enable`, in, 1: when 1 the ramp target is `target_duty`; when 0 the ramp target is 0 (soft stop).
- `target_duty`, in, DUTY_W: requested duty.
- `step`, in, DUTY_W: maximum change per step. A value of 0 is treated as 1.
- `rate_div`, in, RATE_W: a step is taken every `rate_div`+1 clocks.
- `period_sync`, in, 1: one-cycle pulse at the start of each PWM period.
- `duty_out`, out, DUTY_W: registered duty driven to the PWM block.
- `busy`, out, 1: high when the state is not IDLE.
- `at_target`, out, 1: equals `!busy && duty_out == eff_target`.
- `ramp_done`, out, 1: one-cycle pulse when the final step is committed.

## Operation
- Effective target: `eff_target = enable ? target_duty : 0`. It is re-evaluated every cycle and is never latched.
- **IDLE**
  - If `eff_target != duty_out`, go to RAMP and clear the prescaler.
- **RAMP**
  - The prescaler increments every cycle. A tick occurs when prescaler == `rate_div`.
  - On a tick, compute `pending` with 9-bit arithmetic; `duty_out` never wraps:
    - Up: `duty_out + min(step', eff_target - duty_out)`.
    - Down: `duty_out - min(step', duty_out - eff_target)`.
    - `step'` = max(`step`, 1).
  - After the tick, go to COMMIT.
  - If `eff_target == duty_out` on a non-tick cycle, return to IDLE with no pulse. This covers a target moved back mid-wait.
- **COMMIT**
  - Wait for `period_sync`. On the edge where `period_sync` = 1:
    - Set `duty_out <= pending` and clear the prescaler.
    - If `pending == eff_target` (evaluated that cycle), go to IDLE and pulse `ramp_done`.
    - Otherwise go to RAMP.
  - A target change while in COMMIT does not alter `pending`. The new target is honoured from the next step onward, including a direction reversal.
- `period_sync` outside COMMIT is ignored.
- `rate_div` and `step` changes mid-ramp take effect at the next compare or compute.
- The state encoding is internal. Only `busy`, `at_target`, `ramp_done` and `duty_out` are architectural.

## Timing
- Reset (asynchronous, applied immediately):
  - `duty_out` = 0, state = IDLE, prescaler = 0, `pending` = 0.
  - `busy` = 0, `ramp_done` = 0.
  - `at_target` = (`eff_target` == 0).
- Reset asserted mid-ramp forces `duty_out` to 0 immediately. There is no soft stop.
- Target change seen in IDLE at cycle N:
  - RAMP occupies N+1 .. N+1+`rate_div`; the tick is on the last of these cycles.
  - COMMIT starts at N+2+`rate_div`.
  - With `rate_div` = 0, the tick is at N+1 and COMMIT at N+2.
- `duty_out` changes only on an edge where COMMIT and `period_sync` = 1, so the maximum slew is one step per PWM period.
- `ramp_done` is high for exactly the cycle after the final commit, coincident with `busy` falling to 0.
- `busy` and `ramp_done` are registered. `at_target` is combinational from registered state and inputs.

## Test plan
- **Soft start:** reset, `enable`=1, `target_duty`=0x80, `step`=0x10, `rate_div`=3, `period_sync` every 256 clocks. Expect `duty_out` = 0x10, 0x20, …, 0x80 on 8 consecutive sync pulses, one `ramp_done` pulse with 0x80, then `at_target`=1.
- **Clamped last step:** from 0x80, `target_duty`=0x85, `step`=0x10. Expect one commit to 0x85 (no overshoot) and `ramp_done`.
- **Soft stop and saturation:** at 0x85, `enable`=0, `step`=0xFF. Expect a single commit to 0x00 (no wrap) and `busy`=0 afterwards.
- **Step of zero and timing:** `step`=0, `rate_div`=0, 0x00→0x03, `period_sync` held high. Expect 0x01, 0x02, 0x03 on every second clock (RAMP/COMMIT alternation), with the first change 2 cycles after the target change.
- **Reversal mid-ramp:** ramping 0x00→0x40 with step 0x10. After the commit of 0x20, set target 0x08. Expect the next commits to be 0x10 then 0x08, with one `ramp_done`.
- **Async reset mid-COMMIT:** with `pending`=0x30, assert `reset` between clock edges. Expect `duty_out`=0 and `busy`=0 before the next edge, and no `ramp_done`.
